reaction_timer_display: RTL and testbench

- Downstream consumer of the reaction-timer control interface.
- Decodes CounterFlag (clear, stop, start) and ErrorFlag into a millisecond BCD reaction-time counter.
- Drives a 4-digit multiplexed 7-segment display, showing the time as s.mmm or the foul indication "F".
- Sits between the main control logic and the board display pins.

---
 rtl/reaction_timer_display_if.sv | 28 ++
 rtl/reaction_timer_display.sv | 164 ++++++++++++++++
 tb/tb_reaction_timer_display.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_display_if.sv
// Control-side bundle for reaction_timer_display.
// The master drives the flags, and the slave (the display block) returns the count and the display pins.
interface reaction_timer_display_if;
    logic [1:0]  CounterFlag;
    logic        ErrorFlag;
    logic [15:0] time_bcd;
    logic        overflow;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output CounterFlag,
        output ErrorFlag,
        input  time_bcd,
        input  overflow,
        input  an,
        input  seg
    );

    modport slave (
        input  CounterFlag,
        input  ErrorFlag,
        output time_bcd,
        output overflow,
        output an,
        output seg
    );
endinterface

// File: rtl/reaction_timer_display.sv
// Reaction-time BCD millisecond counter with a 4-digit multiplexed 7-segment driver.
// CounterFlag selects clear/hold/run. ErrorFlag replaces the readout with "F".
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
// Digit 3 keeps its dp lit while blanked.
module reaction_timer_display #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    reaction_timer_display_if.slave  bus
);
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        time_q, time_d;
    logic               ovf_q, ovf_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         scan_idx_q, scan_idx_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         digit;
    logic [6:0]         glyph;

    // Add one in BCD. A digit at 9 wraps to 0 and carries into the next digit in the same cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Return active-low segments g..a for one BCD digit. Non-decimal values show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Decode the counter mode. 11 acts as hold, and entering RUN always restarts from zero.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        ovf_d   = ovf_q;
        presc_d = presc_q;
        case (bus.CounterFlag)
            2'b00: begin
                state_d = ST_IDLE;
                time_d  = 16'h0000;
                ovf_d   = 1'b0;
                presc_d = '0;
            end
            2'b10: begin
                if (state_q != ST_RUN) begin
                    state_d = ST_RUN;
                    time_d  = 16'h0000;
                    ovf_d   = 1'b0;
                    presc_d = '0;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    if (time_q == 16'h9999) begin
                        ovf_d = 1'b1;
                    end else begin
                        time_d = bcd_inc(time_q);
                    end
                end else begin
                    presc_d = presc_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Free-running digit scan that walks from digit 3 down to digit 0 and then wraps to 3.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q - 2'd1;
        end
    end

    // Build the anode and segment pattern for the digit currently selected.
    always_comb begin
        an_d  = ~(4'b0001 << scan_idx_q);
        digit = time_q[{scan_idx_q, 2'b00} +: 4];
        glyph = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((scan_idx_q != 2'd0) && ((time_q >> {scan_idx_q, 2'b00}) == 16'd0)) begin
            glyph = 7'h7F;
        end
`endif
        seg_d = {(scan_idx_q != 2'd3), glyph};
        if (bus.ErrorFlag) begin
            seg_d = (scan_idx_q == 2'd3) ? 8'h8E : 8'hFF;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            time_q     <= 16'h0000;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.time_bcd = time_q;
    assign bus.overflow = ovf_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;

endmodule

// File: tb/tb_reaction_timer_display.sv
// Bench for reaction_timer_display.
// A cycle-level integer model pushes the expected outputs for every clock edge, and a monitor pops them on the falling edge.
// The bench uses 4 cycles per tick so that the saturation run stays short, and 4 cycles per digit dwell.
module tb_reaction_timer_display;
    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned TICK_HZ  = 250;
    localparam int unsigned SCAN_HZ  = 250;
    localparam int          TICK_DIV = int'(CLK_HZ / TICK_HZ);
    localparam int          SCAN_DIV = int'(CLK_HZ / SCAN_HZ);

    logic clk_50M;
    logic rst_n;

    reaction_timer_display_if bus();

    reaction_timer_display #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic [15:0] t;
        logic        o;
        logic [3:0]  an;
        logic [7:0]  seg;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    // Model state: mode 0 idle, 1 run, 2 hold; ms is the count as a plain integer.
    int m_mode, m_ms, m_sub, m_edges;
    bit m_ovf;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] numeral(input int d);
        case (d)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            9:       return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int ms, input bit err, input int idx);
        int          pw;
        logic [7:0]  s;
        if (err) return (idx == 3) ? 8'h8E : 8'hFF;
        pw = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        s  = numeral((ms / pw) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx != 0 && ms < pw) s = 8'hFF;
`endif
        if (idx == 3) s[7] = 1'b0;
        return s;
    endfunction

    // Reference model: on every edge, apply the flag rules and queue the expected post-edge outputs.
    initial begin : model
        int   prev_ms;
        int   idx;
        int   f;
        exp_t e;
        forever begin
            @(posedge clk_50M or negedge rst_n);
            if (!rst_n) begin
                m_mode  = 0;
                m_ms    = 0;
                m_sub   = 0;
                m_ovf   = 1'b0;
                m_edges = 0;
                sb_q.delete();
            end else begin
                prev_ms = m_ms;
                idx     = (4 - (m_edges / SCAN_DIV) % 4) % 4;
                e.an    = ~(4'b0001 << idx);
                e.seg   = exp_seg(prev_ms, bus.ErrorFlag, idx);
                f       = int'(bus.CounterFlag);
                if (f == 3) f = 1;
                case (f)
                    0: begin
                        m_mode = 0; m_ms = 0; m_sub = 0; m_ovf = 1'b0;
                    end
                    2: begin
                        if (m_mode != 1) begin
                            m_mode = 1; m_ms = 0; m_sub = 0; m_ovf = 1'b0;
                        end else begin
                            m_sub++;
                            if (m_sub == TICK_DIV) begin
                                m_sub = 0;
                                if (m_ms == 9999) m_ovf = 1'b1;
                                else m_ms++;
                            end
                        end
                    end
                    default: m_mode = 2;
                endcase
                m_edges++;
                e.t = to_bcd(m_ms);
                e.o = m_ovf;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: compare each registered output against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_50M);
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                pops++;
                check("time_bcd", bus.time_bcd, e.t);
                check("overflow", 16'(bus.overflow), 16'(e.o));
                check("an", 16'(bus.an), 16'(e.an));
                check("seg", 16'(bus.seg), 16'(e.seg));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // Observe one full scan and check each digit position against fixed patterns.
    task automatic check_scan(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
        logic [3:0] seen;
        seen = 4'b0000;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge clk_50M);
            case (bus.an)
                4'b0111: begin check({tag, "_d3"}, 16'(bus.seg), 16'(d3)); seen[3] = 1'b1; end
                4'b1011: begin check({tag, "_d2"}, 16'(bus.seg), 16'(d2)); seen[2] = 1'b1; end
                4'b1101: begin check({tag, "_d1"}, 16'(bus.seg), 16'(d1)); seen[1] = 1'b1; end
                4'b1110: begin check({tag, "_d0"}, 16'(bus.seg), 16'(d0)); seen[0] = 1'b1; end
                default: check({tag, "_an_onehot"}, 16'(bus.an), 16'h000E);
            endcase
        end
        check({tag, "_digits_seen"}, 16'(seen), 16'h000F);
        @(posedge clk_50M);
        #1;
    endtask

    initial begin : stimulus
        int r;
        rst_n           = 1'b0;
        bus.CounterFlag = 2'b00;
        bus.ErrorFlag   = 1'b0;
        #12;
        check("rst_time", bus.time_bcd, 16'h0000);
        check("rst_ovf", 16'(bus.overflow), 16'h0000);
        check("rst_an", 16'(bus.an), 16'h000F);
        check("rst_seg", 16'(bus.seg), 16'h00FF);
        step(1);
        rst_n = 1'b1;

        // Idle display of 0000.
        step(3);
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("idle", 8'h7F, 8'hFF, 8'hFF, 8'hC0);
`else
        check_scan("idle", 8'h40, 8'hC0, 8'hC0, 8'hC0);
`endif

        // Run 12 ticks, then hold with 01 and with 11.
        bus.CounterFlag = 2'b10;
        step(1);
        check("entry_zero", bus.time_bcd, 16'h0000);
        step(12 * TICK_DIV);
        check("run_12", bus.time_bcd, 16'h0012);
        bus.CounterFlag = 2'b01;
        step(500);
        check("hold01_12", bus.time_bcd, 16'h0012);
        bus.CounterFlag = 2'b11;
        step(100);
        check("hold11_12", bus.time_bcd, 16'h0012);

        // Restarting from HOLD begins a new trial at 0000.
        bus.CounterFlag = 2'b10;
        step(1);
        check("restart_zero", bus.time_bcd, 16'h0000);

        // Count to 0042, hold it, and check the foul and normal display patterns.
        step(42 * TICK_DIV);
        check("run_42", bus.time_bcd, 16'h0042);
        bus.CounterFlag = 2'b01;
        bus.ErrorFlag   = 1'b1;
        step(2);
        check_scan("foul", 8'h8E, 8'hFF, 8'hFF, 8'hFF);
        bus.ErrorFlag = 1'b0;
        step(2);
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("show42", 8'h7F, 8'hFF, 8'h99, 8'hA4);
`else
        check_scan("show42", 8'h40, 8'hC0, 8'h99, 8'hA4);
`endif
        bus.CounterFlag = 2'b10;
        step(1);
        check("rerun_zero", bus.time_bcd, 16'h0000);

        // Follow the carry chain and saturation in one long run.
        step(99 * TICK_DIV);
        check("run_0099", bus.time_bcd, 16'h0099);
        step(TICK_DIV);
        check("run_0100", bus.time_bcd, 16'h0100);
        step(899 * TICK_DIV);
        check("run_0999", bus.time_bcd, 16'h0999);
        step(TICK_DIV - 1);
        check("pre_1000", bus.time_bcd, 16'h0999);
        step(1);
        check("run_1000", bus.time_bcd, 16'h1000);
        step(8999 * TICK_DIV);
        check("run_9999", bus.time_bcd, 16'h9999);
        check("no_ovf_yet", 16'(bus.overflow), 16'h0000);
        step(TICK_DIV);
        check("sat_9999", bus.time_bcd, 16'h9999);
        check("ovf_set", 16'(bus.overflow), 16'h0001);
        step(10 * TICK_DIV);
        check("ovf_sticky", 16'(bus.overflow), 16'h0001);
        bus.CounterFlag = 2'b00;
        step(1);
        check("clr_time", bus.time_bcd, 16'h0000);
        check("clr_ovf", 16'(bus.overflow), 16'h0000);

        // Random flag and foul sequences, checked by the monitor.
        for (int s = 0; s < 300; s++) begin
            r = int'($urandom_range(0, 9));
            bus.CounterFlag = (r == 0) ? 2'b00 : (r <= 2) ? 2'b01 : (r == 3) ? 2'b11 : 2'b10;
            bus.ErrorFlag   = ($urandom_range(0, 3) == 0);
            step(int'($urandom_range(1, 40)));
        end

        // Assert reset asynchronously in the middle of a run.
        bus.ErrorFlag   = 1'b0;
        bus.CounterFlag = 2'b00;
        step(1);
        bus.CounterFlag = 2'b10;
        step(1 + 37);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", 16'(bus.an), 16'h000F);
        check("async_seg", 16'(bus.seg), 16'h00FF);
        check("async_time", bus.time_bcd, 16'h0000);
        check("async_ovf", 16'(bus.overflow), 16'h0000);
        step(3);
        rst_n = 1'b1;
        step(20);

        check("monitor_active", 16'(pops > 1000), 16'h0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
